// File: rtl/display_stream_rx_if.sv
// Output stream of the display link receiver: captured word plus csel/blank on a
// valid/ready handshake. The receiver is the master and the consumer is the slave.
interface display_stream_rx_if #(
  parameter int unsigned WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] word_ob;
  logic [2:0]            csel_ob3;
  logic                  blank_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (output word_ob, csel_ob3, blank_o, valid_o, input ready_i);
  modport slave  (input word_ob, csel_ob3, blank_o, valid_o, output ready_i);
endinterface

// File: rtl/display_stream_rx.sv
// Display serial link receiver: synchronises sclk/sin/latch/blank/csel into the
// 40 MHz domain, deserialises each latched word MSB first and hands it out on a
// valid/ready stream, flagging length errors, overruns and mid-word timeouts.
module display_stream_rx #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk40m_i,
  input  logic                       reset_ni,
  input  logic                       sclk_i,
  input  logic                       sin_i,
  input  logic                       latch_i,
  input  logic                       blank_i,
  input  logic [2:0]                 csel_ib3,
  display_stream_rx_if.master        stream,
  output logic                       length_err_o,
  output logic                       overrun_o,
  output logic                       timeout_o,
  output logic [7:0]                 err_cnt_ob8
);

  localparam int unsigned CNT_W = $clog2(WORD_WIDTH + 2);
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Bundle order: {csel[2:0], blank, latch, sin, sclk}
  logic [SYNC_STAGES-1:0][6:0] r_sync;
  logic [6:0]                  w_pins;
  logic [6:0]                  w_s;
  logic                        r_sclk_d;
  logic                        r_latch_d;
  logic                        w_sclk_rise;
  logic                        w_latch_rise;

  state_t                      r_state;
  logic [WORD_WIDTH-1:0]       r_shift;
  logic [CNT_W-1:0]            r_count;
  logic [TMR_W-1:0]            r_timer;
  logic [2:0]                  r_csel_cap;
  logic                        r_blank_cap;
  logic [WORD_WIDTH-1:0]       r_word;
  logic [2:0]                  r_csel;
  logic                        r_blank;
  logic                        r_valid;
  logic                        r_length_err;
  logic                        r_overrun;
  logic                        r_timeout;
  logic [7:0]                  r_err_cnt;

  logic [WORD_WIDTH-1:0]       w_shift_next;
  logic [CNT_W-1:0]            w_count_next;
  logic                        w_accept;
  logic [8:0]                  w_err_total;

  assign w_pins       = {csel_ib3, blank_i, latch_i, sin_i, sclk_i};
  assign w_s          = r_sync[SYNC_STAGES-1];
  assign w_sclk_rise  = w_s[0] & ~r_sclk_d;
  assign w_latch_rise = w_s[2] & ~r_latch_d;
  assign w_accept     = r_valid & stream.ready_i;
  assign w_shift_next = {r_shift[WORD_WIDTH-2:0], w_s[1]};
  assign w_count_next = (r_count == CNT_W'(WORD_WIDTH + 1)) ? r_count : r_count + 1'b1;
  assign w_err_total  = {1'b0, r_err_cnt} + 9'(r_length_err) + 9'(r_overrun) + 9'(r_timeout);

  // Equal-depth synchronisers for every link input, plus edge-detect history
  always_ff @(posedge clk40m_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sync    <= '0;
      r_sclk_d  <= 1'b0;
      r_latch_d <= 1'b0;
    end else begin
      r_sync[0] <= w_pins;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_sclk_d  <= w_s[0];
      r_latch_d <= w_s[2];
    end
  end

  // Receive FSM: shift, time out, check the latched word and drive the stream
  always_ff @(posedge clk40m_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_count      <= '0;
      r_timer      <= '0;
      r_csel_cap   <= '0;
      r_blank_cap  <= 1'b0;
      r_word       <= '0;
      r_csel       <= '0;
      r_blank      <= 1'b0;
      r_valid      <= 1'b0;
      r_length_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_length_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_latch_rise) begin
        r_csel_cap  <= w_s[6:4];
        r_blank_cap <= w_s[3];
      end
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (w_sclk_rise) begin
            r_shift <= w_shift_next;
            r_count <= w_count_next;
          end
          if (w_latch_rise) begin
            r_state <= ST_CHECK;
          end else if (w_sclk_rise) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A coincident sclk rise is shifted before the latch sends the word to CHECK
          if (w_sclk_rise) begin
            r_shift <= w_shift_next;
            r_count <= w_count_next;
            r_timer <= '0;
          end
          if (w_latch_rise) begin
            r_state <= ST_CHECK;
          end else if (!w_sclk_rise) begin
            if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
              r_timeout <= 1'b1;
              r_count   <= '0;
              r_shift   <= '0;
              r_timer   <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          // Acceptance in this same cycle frees the slot for the new word
          if (r_count == CNT_W'(WORD_WIDTH)) begin
            if (!r_valid || w_accept) begin
              r_word  <= r_shift;
              r_csel  <= r_csel_cap;
              r_blank <= r_blank_cap;
              r_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_length_err <= 1'b1;
          end
          r_count <= '0;
          r_shift <= '0;
          r_timer <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of error pulses
  always_ff @(posedge clk40m_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_err_cnt <= '0;
    end else if (w_err_total > 9'd255) begin
      r_err_cnt <= 8'hFF;
    end else begin
      r_err_cnt <= w_err_total[7:0];
    end
  end

  assign stream.word_ob  = r_word;
  assign stream.csel_ob3 = r_csel;
  assign stream.blank_o  = r_blank;
  assign stream.valid_o  = r_valid;
  assign length_err_o    = r_length_err;
  assign overrun_o       = r_overrun;
  assign timeout_o       = r_timeout;
  assign err_cnt_ob8     = r_err_cnt;

endmodule

// File: tb/tb_display_stream_rx.sv
// Directed bench for display_stream_rx: drives the serial link bit by bit and
// checks captured words, handshake, error pulses and the saturating error count.
`timescale 1ns/1ps
module tb_display_stream_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       sin = 1'b0;
  logic       latch = 1'b0;
  logic       blank = 1'b0;
  logic [2:0] csel = 3'd0;
  logic       length_err;
  logic       overrun;
  logic       timeout;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Event observers, cleared while reset is held
  int          n_len = 0;
  int          n_ovr = 0;
  int          n_to  = 0;
  int          n_acc = 0;
  logic [15:0] acc_word = '0;
  logic [2:0]  acc_csel = '0;
  logic        acc_blank = 1'b0;

  display_stream_rx_if #(.WORD_WIDTH(16)) stream_if ();

  display_stream_rx #(
    .WORD_WIDTH     (16),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (4096)
  ) dut (
    .clk40m_i     (clk),
    .reset_ni     (rst_n),
    .sclk_i       (sclk),
    .sin_i        (sin),
    .latch_i      (latch),
    .blank_i      (blank),
    .csel_ib3     (csel),
    .stream       (stream_if.master),
    .length_err_o (length_err),
    .overrun_o    (overrun),
    .timeout_o    (timeout),
    .err_cnt_ob8  (err_cnt)
  );

  always #12.5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      n_len = 0; n_ovr = 0; n_to = 0; n_acc = 0;
    end else begin
      n_len += int'(length_err);
      n_ovr += int'(overrun);
      n_to  += int'(timeout);
      if (stream_if.valid_o && stream_if.ready_i) begin
        n_acc++;
        acc_word  = stream_if.word_ob;
        acc_csel  = stream_if.csel_ob3;
        acc_blank = stream_if.blank_o;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    tick(4);
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
    tick(4);
  endtask

  task automatic send_bits(input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(data[i]);
  endtask

  task automatic do_latch(input logic [2:0] cs, input logic bl);
    csel  = cs;
    blank = bl;
    tick(2);
    latch = 1'b1;
    tick(4);
    latch = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sclk = 1'b0; sin = 1'b0; latch = 1'b0; blank = 1'b0; csel = 3'd0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    stream_if.ready_i = 1'b1;

    // Reset state
    tick(2);
    chk("rst_valid_held", 32'(stream_if.valid_o), 32'd0);
    chk("rst_errcnt_held", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("rst_word", 32'(stream_if.word_ob), 32'd0);
    chk("rst_csel", 32'(stream_if.csel_ob3), 32'd0);
    chk("rst_blank", 32'(stream_if.blank_o), 32'd0);
    chk("rst_pulses", 32'({length_err, overrun, timeout}), 32'd0);

    // Good word 0xA5C3, csel 5, blank 0, consumer ready
    send_bits(32'h0000_A5C3, 16);
    do_latch(3'b101, 1'b0);
    tick(4);
    chk("a5c3_acc_cnt", 32'(n_acc), 32'd1);
    chk("a5c3_word", 32'(acc_word), 32'h0000_A5C3);
    chk("a5c3_csel", 32'(acc_csel), 32'd5);
    chk("a5c3_blank", 32'(acc_blank), 32'd0);
    chk("a5c3_valid_low", 32'(stream_if.valid_o), 32'd0);
    chk("a5c3_errcnt", 32'(err_cnt), 32'd0);

    // Short word (15 bits) and long word (17 bits)
    do_reset();
    send_bits(32'h0000_7FFF, 15);
    do_latch(3'b001, 1'b0);
    tick(3);
    chk("len15_err", 32'(n_len), 32'd1);
    chk("len15_no_valid", 32'(n_acc), 32'd0);
    chk("len15_errcnt", 32'(err_cnt), 32'd1);
    send_bits(32'h0001_2345, 17);
    do_latch(3'b010, 1'b1);
    tick(3);
    chk("len17_err", 32'(n_len), 32'd2);
    chk("len17_no_valid", 32'(n_acc), 32'd0);
    chk("len17_errcnt", 32'(err_cnt), 32'd2);

    // Overrun: consumer stalled, second word dropped; also latch-to-valid latency
    do_reset();
    stream_if.ready_i = 1'b0;
    send_bits(32'h0000_1234, 16);
    csel = 3'b011;
    blank = 1'b1;
    tick(2);
    latch = 1'b1;
    tick(3);
    chk("lat_not_yet", 32'(stream_if.valid_o), 32'd0);
    tick(1);
    chk("lat_valid", 32'(stream_if.valid_o), 32'd1);
    chk("ovr_first_word", 32'(stream_if.word_ob), 32'h0000_1234);
    tick(2);
    latch = 1'b0;
    tick(4);
    send_bits(32'h0000_5678, 16);
    do_latch(3'b110, 1'b0);
    tick(3);
    chk("ovr_pulse", 32'(n_ovr), 32'd1);
    chk("ovr_valid_held", 32'(stream_if.valid_o), 32'd1);
    chk("ovr_word_held", 32'(stream_if.word_ob), 32'h0000_1234);
    chk("ovr_csel_held", 32'(stream_if.csel_ob3), 32'd3);
    chk("ovr_errcnt", 32'(err_cnt), 32'd1);
    stream_if.ready_i = 1'b1;
    chk("ovr_valid_until_edge", 32'(stream_if.valid_o), 32'd1);
    tick(1);
    chk("ovr_valid_fell", 32'(stream_if.valid_o), 32'd0);
    chk("ovr_acc_cnt", 32'(n_acc), 32'd1);
    chk("ovr_acc_word", 32'(acc_word), 32'h0000_1234);

    // Timeout after 8 bits, then a clean 0xBEEF
    do_reset();
    send_bits(32'h0000_00AB, 8);
    tick(4110);
    chk("to_pulse", 32'(n_to), 32'd1);
    chk("to_errcnt", 32'(err_cnt), 32'd1);
    chk("to_no_valid", 32'(n_acc), 32'd0);
    send_bits(32'h0000_BEEF, 16);
    do_latch(3'b010, 1'b1);
    tick(3);
    chk("beef_acc_cnt", 32'(n_acc), 32'd1);
    chk("beef_word", 32'(acc_word), 32'h0000_BEEF);
    chk("beef_blank", 32'(acc_blank), 32'd1);
    chk("beef_no_len_err", 32'(n_len), 32'd0);

    // Reset in the middle of a word, then 0x00FF
    do_reset();
    send_bits(32'h0000_03FF, 10);
    do_reset();
    send_bits(32'h0000_00FF, 16);
    do_latch(3'b111, 1'b0);
    tick(3);
    chk("midrst_acc_cnt", 32'(n_acc), 32'd1);
    chk("midrst_word", 32'(acc_word), 32'h0000_00FF);
    chk("midrst_csel", 32'(acc_csel), 32'd7);
    chk("midrst_errs", 32'(n_len + n_ovr + n_to), 32'd0);
    chk("midrst_errcnt", 32'(err_cnt), 32'd0);

    // Error counter saturation with empty latches
    do_reset();
    for (int i = 0; i < 254; i++) do_latch(3'b000, 1'b0);
    tick(2);
    chk("sat_254", 32'(err_cnt), 32'd254);
    for (int i = 0; i < 46; i++) do_latch(3'b000, 1'b0);
    tick(2);
    chk("sat_len_pulses", 32'(n_len), 32'd300);
    chk("sat_255", 32'(err_cnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
